// File: rtl/mem_rw_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg                                                                  |
// | Shared defaults, operation encoding and sizing helper for mem_rw_ctrl.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_RD_LAT = 4;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  // Response FIFO depth doubles as the read-credit limit.
  function automatic int rsp_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rw_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_rw_ctrl_if                                                           |
// | Request (valid/ready) and response (valid/ready) channels of the memory. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mem_rw_ctrl_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/mem_rw_ctrl_rsp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_rsp_fifo                                                             |
// | Small circular response FIFO; head is stable until popped.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_rsp_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_store [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  // Depth need not be a power of two, so pointers wrap explicitly.
  assign w_wr_ptr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;

  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);
  assign o_head  = r_store[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (i_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_store[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      a_no_overflow:  assert (!(i_push && o_full));
      a_no_underflow: assert (!(i_pop && o_empty));
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_rw_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_rw_ctrl                                                              |
// | Single-port memory with credit-limited reads and an in-order response    |
// | FIFO; reads of never-written words return zero with an error flag.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_rw_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_,
  mem_rw_ctrl_if.slave  mem_if
);

  localparam int RSP_DEPTH = rsp_depth(RD_LAT);
  localparam int WORDS     = 2 ** ADDR_W;
  localparam int ENTRY_W   = DATA_W + 1;
  localparam int OUT_W     = $clog2(RSP_DEPTH + 1);
  localparam logic [OUT_W-1:0] c_rsp_depth = OUT_W'(RSP_DEPTH);

  generate
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
      $fatal(1, "mem_rw_ctrl: RD_LAT must lie within 1..4");
    end
  endgenerate

  logic [DATA_W-1:0]  r_mem [WORDS];
  logic [WORDS-1:0]   r_written;
  logic [OUT_W-1:0]   r_outstanding;

  mem_op_e            w_op;
  logic               w_req_fire;
  logic               w_wr_fire;
  logic               w_rd_fire;
  logic               w_rsp_fire;
  logic [ENTRY_W-1:0] w_rd_entry;
  logic               w_push;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;

  assign w_op             = mem_op_e'(mem_if.req_write);
  assign mem_if.req_ready = (r_outstanding < c_rsp_depth);
  assign w_req_fire       = mem_if.req_valid && mem_if.req_ready;
  assign w_wr_fire        = w_req_fire && (w_op == MEM_WR);
  assign w_rd_fire        = w_req_fire && (w_op == MEM_RD);
  assign w_rsp_fire       = mem_if.rsp_valid && mem_if.rsp_ready;

  // Entry layout is {err, data}; unwritten words read as zero with err set.
  always_comb begin
    w_rd_entry = {1'b1, {DATA_W{1'b0}}};
    if (r_written[mem_if.req_addr]) begin
      w_rd_entry = {1'b0, r_mem[mem_if.req_addr]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_ && w_wr_fire) r_mem[mem_if.req_addr] <= mem_if.req_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_)          r_written <= '0;
    else if (w_wr_fire) r_written[mem_if.req_addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_)                        r_outstanding <= '0;
    else if (w_rd_fire && !w_rsp_fire) r_outstanding <= r_outstanding + 1'b1;
    else if (!w_rd_fire && w_rsp_fire) r_outstanding <= r_outstanding - 1'b1;
  end

  // The FIFO write is the last latency stage, so RD_LAT-1 register stages precede it.
  generate
    if (RD_LAT <= 1) begin : g_direct
      assign w_push       = w_rd_fire;
      assign w_push_entry = w_rd_entry;
    end else begin : g_pipe
      localparam int STAGES = RD_LAT - 1;
      logic [STAGES-1:0]  r_vld;
      logic [ENTRY_W-1:0] r_ent [STAGES];

      always_ff @(posedge clk) begin
        if (!rst_) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= w_rd_fire;
          for (int s = 1; s < STAGES; s++) r_vld[s] <= r_vld[s-1];
        end
      end

      always_ff @(posedge clk) begin
        r_ent[0] <= w_rd_entry;
        for (int s = 1; s < STAGES; s++) r_ent[s] <= r_ent[s-1];
      end

      assign w_push       = r_vld[STAGES-1];
      assign w_push_entry = r_ent[STAGES-1];
    end
  endgenerate

  mem_rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_rsp_fire),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign mem_if.rsp_valid = !w_empty;
  assign mem_if.rsp_data  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign mem_if.rsp_err   = !w_empty && w_head[ENTRY_W-1];

  // A full FIFO means every credit is held by a queued response.
  always_ff @(posedge clk) begin
    if (rst_) begin
      a_credit_match: assert (!w_full || (r_outstanding == c_rsp_depth));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_rw_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_rw_ctrl                                                           |
// | Directed checks of mem_rw_ctrl at RD_LAT=1 (u_dut1) and RD_LAT=3 (u_dut3)|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_rw_ctrl;

  localparam int DW = 8;
  localparam int AW = 5;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  mem_rw_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  mem_rw_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if3 ();

  mem_rw_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk    (clk),
    .rst_   (rst_),
    .mem_if (if1)
  );

  mem_rw_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
    .clk    (clk),
    .rst_   (rst_),
    .mem_if (if3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_all();
    if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0;
    if1.req_wdata = '0;   if1.rsp_ready = 1'b0;
    if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_addr = '0;
    if3.req_wdata = '0;   if3.rsp_ready = 1'b0;
  endtask

  task automatic wr3(input logic [4:0] a, input logic [7:0] d);
    if3.req_valid = 1'b1; if3.req_write = 1'b1;
    if3.req_addr  = a;    if3.req_wdata = d;
    step();
    if3.req_valid = 1'b0; if3.req_write = 1'b0;
  endtask

  task automatic drain3(input string tag, input int n, input int base);
    int got;
    got = 0;
    if3.rsp_ready = 1'b1;
    for (int c = 0; c < 30 && got < n; c++) begin
      sample();
      if (if3.rsp_valid) begin
        chk($sformatf("%s_data%0d", tag, got), 32'(if3.rsp_data), base + got);
        chk($sformatf("%s_err%0d", tag, got), 32'(if3.rsp_err), 0);
        got++;
      end
      step();
    end
    if3.rsp_ready = 1'b0;
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got, nxt, seen, found, found_c;
    logic stall_prev;
    logic [7:0] held;

    idle_all();
    rst_ = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    chk("rst_req_ready1", 32'(if1.req_ready), 1);
    chk("rst_rsp_valid1", 32'(if1.rsp_valid), 0);
    chk("rst_rsp_data1",  32'(if1.rsp_data),  0);
    chk("rst_rsp_err1",   32'(if1.rsp_err),   0);
    chk("rst_req_ready3", 32'(if3.req_ready), 1);
    chk("rst_rsp_valid3", 32'(if3.rsp_valid), 0);
    step();
    rst_ = 1'b1;
    step();

    // Read of an unwritten word, RD_LAT=1.
    if1.rsp_ready = 1'b1; if1.req_valid = 1'b1; if1.req_write = 1'b0; if1.req_addr = 5'd5;
    sample();
    chk("t1_ready",      32'(if1.req_ready), 1);
    chk("t1_no_rsp_yet", 32'(if1.rsp_valid), 0);
    step();
    if1.req_valid = 1'b0;
    sample();
    chk("t1_rsp_valid", 32'(if1.rsp_valid), 1);
    chk("t1_rsp_data",  32'(if1.rsp_data),  0);
    chk("t1_rsp_err",   32'(if1.rsp_err),   1);
    step();
    sample();
    chk("t1_rsp_gone", 32'(if1.rsp_valid), 0);
    step();

    // Write in N, read same word in N+1.
    if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_addr = 5'd3; if1.req_wdata = 8'hA5;
    step();
    if1.req_write = 1'b0;
    sample();
    chk("t2_no_wr_rsp", 32'(if1.rsp_valid), 0);
    step();
    if1.req_valid = 1'b0;
    sample();
    chk("t2_rsp_valid", 32'(if1.rsp_valid), 1);
    chk("t2_rsp_data",  32'(if1.rsp_data),  32'h0000_00A5);
    chk("t2_rsp_err",   32'(if1.rsp_err),   0);
    step();

    // Fill all 32 words, then read back with random consumer stalls.
    if1.rsp_ready = 1'b0;
    for (int a = 0; a < 32; a++) begin
      if1.req_valid = 1'b1; if1.req_write = 1'b1;
      if1.req_addr  = 5'(a); if1.req_wdata = 8'(a) ^ 8'h3C;
      step();
    end
    if1.req_write = 1'b0;
    nxt = 0; got = 0; stall_prev = 1'b0; held = '0;
    for (int c = 0; c < 400 && got < 32; c++) begin
      if1.req_valid = (nxt < 32);
      if1.req_addr  = 5'(nxt);
      if1.rsp_ready = ($urandom_range(0, 3) != 0);
      sample();
      if (stall_prev) begin
        chk("t4_stall_valid", 32'(if1.rsp_valid), 1);
        chk("t4_stall_data",  32'(if1.rsp_data),  32'(held));
      end
      if (if1.req_valid && if1.req_ready) begin
        exp_q.push_back(8'(nxt) ^ 8'h3C);
        nxt++;
      end
      if (if1.rsp_valid && if1.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("t4_spurious_rsp", 32'(if1.rsp_valid), 0);
        end else begin
          chk($sformatf("t4_data%0d", got), 32'(if1.rsp_data), 32'(exp_q.pop_front()));
          chk($sformatf("t4_err%0d", got),  32'(if1.rsp_err),  0);
        end
        got++;
      end
      stall_prev = if1.rsp_valid && !if1.rsp_ready;
      held       = if1.rsp_data;
      step();
    end
    chk("t4_count", got, 32);
    if1.req_valid = 1'b0; if1.rsp_ready = 1'b0;

    // RD_LAT=3: credit limit of 5 under full backpressure.
    for (int i = 0; i < 6; i++) wr3(5'(10 + i), 8'(8'h50 + i));
    if3.rsp_ready = 1'b0; if3.req_valid = 1'b1; if3.req_write = 1'b0; if3.req_addr = 5'd10;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (if3.req_ready) acc++;
      step();
      if3.req_addr = 5'(10 + acc);
    end
    if3.req_valid = 1'b0;
    sample();
    chk("t3_accepted", acc, 5);
    chk("t3_ready_low", 32'(if3.req_ready), 0);
    step();
    if3.rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      sample();
      if (c == 0) chk("t3_ready_at_pop",    32'(if3.req_ready), 0);
      if (c == 1) chk("t3_ready_after_pop", 32'(if3.req_ready), 1);
      if (if3.rsp_valid) begin
        chk($sformatf("t3_data%0d", got), 32'(if3.rsp_data), 8'h50 + got);
        chk($sformatf("t3_err%0d", got),  32'(if3.rsp_err),  0);
        got++;
      end
      step();
    end
    chk("t3_count", got, 5);
    if3.rsp_ready = 1'b0;
    sample();
    chk("t3_ready_end", 32'(if3.req_ready), 1);
    chk("t3_empty_end", 32'(if3.rsp_valid), 0);
    step();

    // Outstanding at 4: simultaneous accept and pop keeps it at 4.
    if3.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if3.req_addr = 5'(10 + i);
      step();
    end
    if3.req_addr = 5'd14; if3.rsp_ready = 1'b1;
    sample();
    chk("t5_ready_same", 32'(if3.req_ready), 1);
    chk("t5_valid_same", 32'(if3.rsp_valid), 1);
    chk("t5_head_same",  32'(if3.rsp_data),  32'h50);
    step();
    if3.req_addr = 5'd15; if3.rsp_ready = 1'b0;
    sample();
    chk("t5_ready_kept", 32'(if3.req_ready), 1);
    step();
    if3.req_valid = 1'b0;
    sample();
    chk("t5_ready_full", 32'(if3.req_ready), 0);
    step();
    drain3("t5", 5, 32'h51);

    // Reset with three reads in flight.
    if3.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if3.req_addr = 5'(10 + i);
      step();
    end
    if3.req_valid = 1'b0;
    rst_ = 1'b0;
    step();
    rst_ = 1'b1; if3.rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (if3.rsp_valid) seen++;
      step();
    end
    chk("t6_no_rsp", seen, 0);
    sample();
    chk("t6_ready", 32'(if3.req_ready), 1);
    step();
    if3.req_valid = 1'b1; if3.req_addr = 5'd10;
    found = 0; found_c = -1;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (if3.rsp_valid) begin
        chk("t6_data", 32'(if3.rsp_data), 0);
        chk("t6_err",  32'(if3.rsp_err),  1);
        if (found == 0) found_c = c;
        found++;
      end
      step();
      if3.req_valid = 1'b0;
    end
    chk("t6_found",   found,   1);
    chk("t6_latency", found_c, 3);
    idle_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
